// File: rtl/imem_fetch_cache.sv
// imem_fetch_cache: direct-mapped instruction cache for the IF stage.
// A miss stalls the fetch, reads one 8-word line beat by beat from backing
// memory, commits the tag/valid bit, then the lookup is retried.
// Optional build macro ICACHE_STATS_EN adds HIT_CNT / MISS_CNT outputs.
module imem_fetch_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        PC_VALID,
  input  logic        FLUSH,
  output logic [31:0] INSTR,
  output logic        HIT,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_RVALID
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 27 - IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [26:0]        base_line;   // PC[31:5] of the line being filled
  logic [2:0]         beat;

  logic [31:0]        data_ram [LINES*WORDS];
  logic [TAG_W-1:0]   tag_ram  [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         off;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               accept;
  logic               unused_pc_bits;

  assign idx      = PC[5 +: IDX_W];
  assign tag      = PC[31 -: TAG_W];
  assign off      = PC[4:2];
  assign fill_idx = base_line[IDX_W-1:0];
  assign fill_tag = base_line[26 -: TAG_W];
  assign unused_pc_bits = ^PC[1:0];

  // Lookup is only meaningful in IDLE; a concurrent FLUSH forces a miss.
  assign lookup_hit = !RESET && (state == S_IDLE) && PC_VALID && !FLUSH &&
                      valid[idx] && (tag_ram[idx] == tag);
  assign accept     = (state == S_FILL) && MEM_REQ && MEM_RVALID;

  assign HIT   = lookup_hit;
  assign INSTR = lookup_hit ? data_ram[{idx, off}] : NOP;
  assign STALL = !RESET && ((state != S_IDLE) || (PC_VALID && !lookup_hit));

  // Fill controller: tracks line base, beat and the memory request.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      valid     <= '0;
      beat      <= '0;
      base_line <= '0;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
    end else if (FLUSH) begin
      state     <= S_IDLE;
      valid     <= '0;
      beat      <= '0;
      MEM_REQ   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (PC_VALID && !lookup_hit) begin
            base_line <= PC[31:5];
            beat      <= '0;
            MEM_ADDR  <= {PC[31:5], 5'b0};
            MEM_REQ   <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            beat     <= 3'(beat + 3'd1);
            MEM_ADDR <= {base_line, 3'(beat + 3'd1), 2'b00};
            if (beat == 3'd7) begin
              MEM_REQ <= 1'b0;
              state   <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          valid[fill_idx] <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays: written by the fill, never reset.
  // NOTE: RAM contents are left unreset on purpose; the valid bits alone
  // decide whether a line is usable, which keeps the arrays mappable to SRAM.
  always_ff @(posedge CLK) begin
    if (accept && !FLUSH)
      data_ram[{fill_idx, beat}] <= MEM_RDATA;
    if ((state == S_COMMIT) && !FLUSH)
      tag_ram[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  // Lookup statistics: one count per IDLE lookup cycle, wrapping at 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else if ((state == S_IDLE) && PC_VALID && !FLUSH) begin
      if (lookup_hit) HIT_CNT  <= HIT_CNT + 32'd1;
      else            MISS_CNT <= MISS_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_cache.sv
// tb_imem_fetch_cache: randomized and directed bench for imem_fetch_cache.
// Backing memory holds word 0x1000 + (addr>>2); a line-level model predicts
// hit/miss, miss latency and instruction words.
module tb_imem_fetch_cache;

  localparam int LINES = 16;
  localparam int IDX_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PC = '0;
  logic        PC_VALID = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] INSTR;
  logic        HIT;
  logic        STALL;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_RVALID = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] HIT_CNT;
  logic [31:0] MISS_CNT;
`endif

  imem_fetch_cache #(.LINES(LINES), .WORDS(8)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .PC_VALID(PC_VALID), .FLUSH(FLUSH),
    .INSTR(INSTR), .HIT(HIT), .STALL(STALL), .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID)
`ifdef ICACHE_STATS_EN
    , .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Line-level model: which line address is resident per index.
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];
  int          exp_hits;
  int          exp_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[idx_of(a)] && (mtag[idx_of(a)] == (a >> (5 + IDX_W)));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      PC_VALID = 1'b0; FLUSH = 1'b0; MEM_RVALID = 1'b0;
    end
  endtask

  // Present pc until HIT; serve the fill with the given rvalid period
  // (0 = random gaps plus junk rvalid while no request is pending).
  task automatic fetch(input logic [31:0] pc, input int period, output int stall);
    logic [31:0] base;
    bit exp_hit, done;
    int k, n, last_iter, exp_stall;
    base = {pc[31:5], 5'b0};
    exp_hit = model_hit(pc);
    k = 0; n = 0; last_iter = -1; done = 0; stall = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK);
      if (i == 0) begin PC = pc; PC_VALID = 1'b1; end
      if (MEM_REQ) begin
        MEM_RVALID = (period == 0) ? 1'($urandom_range(0, 1)) : ((n % period) == period - 1);
        MEM_RDATA  = mem_word(MEM_ADDR);
        n++;
      end else begin
        MEM_RVALID = (period == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        MEM_RDATA  = $urandom;
      end
      #1;
      checks++;
      if (HIT && MEM_REQ) begin errors++; $display("FAIL hit_memreq_excl pc=%h both high", pc); end
      if (MEM_REQ) begin
        checks++;
        if (MEM_ADDR !== base + 32'(4 * k)) begin
          errors++; $display("FAIL fill_addr pc=%h got=%h exp=%h", pc, MEM_ADDR, base + 32'(4 * k));
        end
        if (MEM_RVALID) begin k++; if (k == 8) last_iter = i; end
      end
      if (HIT === 1'b1) begin
        checks++;
        if (INSTR !== mem_word({pc[31:2], 2'b00})) begin
          errors++; $display("FAIL instr pc=%h got=%h exp=%h", pc, INSTR, mem_word({pc[31:2], 2'b00}));
        end
        checks++;
        if (STALL !== 1'b0) begin errors++; $display("FAIL stall_on_hit pc=%h got=%b exp=0", pc, STALL); end
        done = 1;
      end else begin
        stall++;
        checks++;
        if (STALL !== 1'b1) begin errors++; $display("FAIL stall_on_miss pc=%h got=%b exp=1", pc, STALL); end
      end
    end
    MEM_RVALID = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL fetch_timeout pc=%h got=no_hit exp=hit", pc); end
    exp_stall = exp_hit ? 0 : last_iter + 2;
    checks++;
    if (stall != exp_stall) begin
      errors++; $display("FAIL latency pc=%h got=%0d exp=%0d", pc, stall, exp_stall);
    end
    mvalid[idx_of(pc)] = 1'b1;
    mtag[idx_of(pc)]   = pc >> (5 + IDX_W);
    exp_hits++;
    if (!exp_hit) exp_misses++;
  endtask

  task automatic expect_stall(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin errors++; $display("FAIL %s got=%0d exp=%0d", name, got, exp); end
  endtask

  task automatic test_reset();
    PC = 32'h0; PC_VALID = 1'b1; RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (HIT !== 1'b0)     begin errors++; $display("FAIL reset_hit got=%b exp=0", HIT); end
    checks++; if (STALL !== 1'b0)   begin errors++; $display("FAIL reset_stall got=%b exp=0", STALL); end
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_memreq got=%b exp=0", MEM_REQ); end
    checks++; if (MEM_ADDR !== '0)  begin errors++; $display("FAIL reset_memaddr got=%h exp=0", MEM_ADDR); end
    checks++; if (INSTR !== NOP)    begin errors++; $display("FAIL reset_instr got=%h exp=%h", INSTR, NOP); end
    @(negedge CLK);
    RESET = 1'b0; PC_VALID = 1'b0;
    model_clear(); exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_cold_and_hits();
    int st;
    fetch(32'h0000_0000, 1, st); expect_stall("cold_miss_stall", st, 10);
    fetch(32'h0000_0004, 1, st); expect_stall("hit_04_stall", st, 0);
    fetch(32'h0000_0008, 1, st); expect_stall("hit_08_stall", st, 0);
    fetch(32'h0000_001C, 1, st); expect_stall("hit_1c_stall", st, 0);
  endtask

  task automatic test_conflict();
    int st;
    fetch(32'h0000_0200, 1, st); expect_stall("conflict_200", st, 10);
    fetch(32'h0000_0000, 1, st); expect_stall("conflict_back_0", st, 10);
  endtask

  task automatic test_throttled();
    int st;
    fetch(32'h0000_0040, 3, st); expect_stall("throttled_stall", st, 26);
    for (int w = 0; w < 8; w++) begin
      fetch(32'h0000_0040 + 32'(4 * w), 1, st); expect_stall("throttled_word_hit", st, 0);
    end
  endtask

  task automatic test_flush();
    int k, st;
    bit reached;
    k = 0; reached = 0;
    @(negedge CLK); PC = 32'h0000_0120; PC_VALID = 1'b1; MEM_RVALID = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge CLK);
      if (k == 4) begin
        FLUSH = 1'b1; MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
        #1;
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h0000_0130) begin
          errors++; $display("FAIL flush_beat4 got=%b/%h exp=1/00000130", MEM_REQ, MEM_ADDR);
        end
        reached = 1;
      end else begin
        MEM_RVALID = MEM_REQ; MEM_RDATA = mem_word(MEM_ADDR);
        if (MEM_REQ) k++;
      end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL flush_reach_timeout got=%0d exp=4", k); end
    @(negedge CLK);
    FLUSH = 1'b0; PC_VALID = 1'b0; MEM_RVALID = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || STALL !== 1'b0 || HIT !== 1'b0) begin
      errors++; $display("FAIL flush_abort got=req%b stall%b hit%b exp=000", MEM_REQ, STALL, HIT);
    end
    model_clear();
    fetch(32'h0000_0120, 1, st); expect_stall("flush_refetch", st, 10);
    fetch(32'h0000_0000, 1, st); expect_stall("flush_cleared_0", st, 10);
    // FLUSH coinciding with an IDLE lookup of a resident line
    @(negedge CLK); PC = 32'h0000_0120; PC_VALID = 1'b1; FLUSH = 1'b1;
    #1;
    checks++;
    if (HIT !== 1'b0) begin errors++; $display("FAIL flush_idle_hit got=%b exp=0", HIT); end
    @(negedge CLK); FLUSH = 1'b0; PC_VALID = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL flush_idle_nofill got=%b exp=0", MEM_REQ); end
    model_clear();
    fetch(32'h0000_0120, 1, st); expect_stall("flush_idle_refetch", st, 10);
  endtask

  task automatic test_reset_midfill();
    int k, st;
    k = 0;
    @(negedge CLK); PC = 32'h0000_0000; PC_VALID = 1'b1; MEM_RVALID = 1'b0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge CLK);
      MEM_RVALID = MEM_REQ; MEM_RDATA = mem_word(MEM_ADDR);
      if (MEM_REQ) k++;
    end
    @(posedge CLK); #2;
    MEM_RVALID = 1'b0;
    RESET = 1'b1;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || MEM_ADDR !== '0 || STALL !== 1'b0 || HIT !== 1'b0 || INSTR !== NOP) begin
      errors++; $display("FAIL async_reset got=req%b addr%h stall%b hit%b instr%h exp=0/0/0/0/%h",
                         MEM_REQ, MEM_ADDR, STALL, HIT, INSTR, NOP);
    end
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0; PC_VALID = 1'b0;
    model_clear(); exp_hits = 0; exp_misses = 0;
`ifdef ICACHE_STATS_EN
    #1;
    checks++;
    if (HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0) begin
      errors++; $display("FAIL stats_after_reset got=%0d/%0d exp=0/0", HIT_CNT, MISS_CNT);
    end
`endif
    fetch(32'h0000_0120, 1, st); expect_stall("reset_cleared_120", st, 10);
    fetch(32'h0000_0000, 1, st); expect_stall("reset_fill_aborted_0", st, 10);
  endtask

  task automatic test_stats();
    int st;
    @(negedge CLK); RESET = 1'b1; PC_VALID = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    model_clear(); exp_hits = 0; exp_misses = 0;
    fetch(32'h0000_0000, 1, st); expect_stall("stats_miss", st, 10);
    fetch(32'h0000_0004, 1, st);
    fetch(32'h0000_0008, 1, st);
    idle_cycles(1);
`ifdef ICACHE_STATS_EN
    #1;
    checks++;
    if (HIT_CNT !== 32'(exp_hits) || MISS_CNT !== 32'(exp_misses)) begin
      errors++; $display("FAIL stats_counts got=%0d/%0d exp=%0d/%0d", HIT_CNT, MISS_CNT, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_random();
    int st;
    logic [31:0] pc;
    for (int t = 0; t < 60; t++) begin
      pc = (32'($urandom_range(0, 2)) << (5 + IDX_W)) | (32'($urandom_range(0, LINES - 1)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      fetch(pc, int'($urandom_range(0, 3)), st);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge CLK); PC_VALID = 1'b0; FLUSH = 1'b1;
        @(negedge CLK); FLUSH = 1'b0;
        model_clear();
      end else if ($urandom_range(0, 3) == 0) begin
        idle_cycles(1);
      end
    end
    idle_cycles(1);
`ifdef ICACHE_STATS_EN
    #1;
    checks++;
    if (HIT_CNT !== 32'(exp_hits) || MISS_CNT !== 32'(exp_misses)) begin
      errors++; $display("FAIL random_stats got=%0d/%0d exp=%0d/%0d", HIT_CNT, MISS_CNT, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    test_reset();
    test_cold_and_hits();
    test_conflict();
    test_throttled();
    test_flush();
    test_reset_midfill();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
